// File: rtl/reg_writeback_pkg.sv
// Shared widths and the writeback packet carried from execute/memory to the
// register file write port.
package reg_writeback_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned PKT_W      = REG_ADDR_W + XLEN;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_pkt_t;

    // True when a write to rd would actually change architectural state.
    function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd);
        return rd != REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// Synchronous FIFO for load results that lost arbitration; push and pop may
// happen in the same cycle, and pushes into a full FIFO are ignored.
module wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [PKT_W-1:0] din,
    output logic [PKT_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback: merges ALU and load results onto the single write
// port, buffers losing loads, and tracks pending loads per register.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issueValid,
    input  logic                  issueIsLoad,
    input  logic [REG_ADDR_W-1:0] issueRd,
    input  logic                  aluValid,
    input  logic [REG_ADDR_W-1:0] aluRd,
    input  logic [XLEN-1:0]       aluData,
    input  logic                  ldValid,
    input  logic [REG_ADDR_W-1:0] ldRd,
    input  logic [XLEN-1:0]       ldData,
    output logic                  ldReady,
    output logic                  wEn,
    output logic [REG_ADDR_W-1:0] addrD,
    output logic [XLEN-1:0]       dataD,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  wbStall,
    output logic                  errWaw
);

    localparam int unsigned AGE_W = $clog2(MAX_WAIT + 1);

    wb_pkt_t             fifo_head;
    wb_pkt_t             ld_pkt;
    wb_pkt_t             sel_pkt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                bypass;
    logic                sel_valid;
    logic                sel_load;
    logic                waw_hit;
    logic [NUM_REGS-1:0] busy_d;
    logic [AGE_W-1:0]    age_q;
    logic [AGE_W-1:0]    age_d;

    assign ld_pkt  = '{rd: ldRd, data: ldData};
    assign ldReady = ~fifo_full;
    assign bypass  = ~aluValid & fifo_empty & ldValid;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (ld_pkt),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fixed-priority select: ALU, then oldest buffered load, then bypass.
    always_comb begin
        sel_valid = 1'b0;
        sel_load  = 1'b0;
        sel_pkt   = '0;
        fifo_pop  = 1'b0;
        if (aluValid) begin
            sel_valid = 1'b1;
            sel_pkt   = '{rd: aluRd, data: aluData};
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_load  = 1'b1;
            sel_pkt   = fifo_head;
            fifo_pop  = 1'b1;
        end else if (ldValid) begin
            sel_valid = 1'b1;
            sel_load  = 1'b1;
            sel_pkt   = ld_pkt;
        end
        fifo_push = ldValid & ldReady & ~bypass;
    end

    // Clear on load writeback first so a same-cycle re-issue keeps the bit set.
    always_comb begin
        busy_d = busy;
        if (sel_load && writes_reg(sel_pkt.rd)) begin
            busy_d[sel_pkt.rd] = 1'b0;
        end
        if (issueValid && issueIsLoad && writes_reg(issueRd)) begin
            busy_d[issueRd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Age counts cycles the head loses to the ALU, saturating at MAX_WAIT.
    always_comb begin
        age_d = age_q;
        if (fifo_empty || fifo_pop) begin
            age_d = '0;
        end else if (aluValid && (age_q < AGE_W'(MAX_WAIT))) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    assign waw_hit = aluValid & writes_reg(aluRd) & busy[aluRd];

    always_ff @(posedge clk) begin
        if (rst) begin
            wEn     <= 1'b0;
            addrD   <= '0;
            dataD   <= '0;
            busy    <= '0;
            wbStall <= 1'b0;
            errWaw  <= 1'b0;
            age_q   <= '0;
        end else begin
            wEn <= sel_valid & writes_reg(sel_pkt.rd);
            if (sel_valid) begin
                addrD <= sel_pkt.rd;
                dataD <= sel_pkt.data;
            end
            busy    <= busy_d;
            wbStall <= (age_q >= AGE_W'(MAX_WAIT));
            if (waw_hit) begin
                errWaw <= 1'b1;
            end
            age_q <= age_d;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_reg_writeback;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned MAX_WAIT   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        issueValid;
    logic        issueIsLoad;
    logic [4:0]  issueRd;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        ldValid;
    logic [4:0]  ldRd;
    logic [31:0] ldData;
    logic        ldReady;
    logic        wEn;
    logic [4:0]  addrD;
    logic [31:0] dataD;
    logic [31:0] busy;
    logic        wbStall;
    logic        errWaw;

    int n_checks = 0;
    int n_errors = 0;

    reg_writeback #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issueValid  (issueValid),
        .issueIsLoad (issueIsLoad),
        .issueRd     (issueRd),
        .aluValid    (aluValid),
        .aluRd       (aluRd),
        .aluData     (aluData),
        .ldValid     (ldValid),
        .ldRd        (ldRd),
        .ldData      (ldData),
        .ldReady     (ldReady),
        .wEn         (wEn),
        .addrD       (addrD),
        .dataD       (dataD),
        .busy        (busy),
        .wbStall     (wbStall),
        .errWaw      (errWaw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: a queue of waiting loads, a busy bit array, and
    // the expected register-file write for the cycle after each edge.
    logic [36:0] m_q [$];
    logic [31:0] m_busy;
    logic        m_err;
    int          m_age;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_stall;
    logic        m_init = 1'b0;

    logic        s_sel;
    logic        s_isld;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic [36:0] s_pkt;
    logic        s_room;
    logic        s_empty;
    logic        s_pop;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_busy  = '0;
            m_err   = 1'b0;
            m_age   = 0;
            m_wen   = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            m_stall = 1'b0;
            m_init  = 1'b1;
        end else if (m_init) begin
            s_empty = (m_q.size() == 0);
            s_room  = (m_q.size() < FIFO_DEPTH);
            s_sel   = 1'b0;
            s_isld  = 1'b0;
            s_pop   = 1'b0;
            s_rd    = '0;
            s_data  = '0;
            if (aluValid && aluRd != 0 && m_busy[aluRd]) m_err = 1'b1;
            m_stall = (m_age >= MAX_WAIT);
            if (aluValid) begin
                s_sel = 1'b1; s_rd = aluRd; s_data = aluData;
                if (ldValid && s_room) m_q.push_back({ldRd, ldData});
            end else if (!s_empty) begin
                s_pkt = m_q.pop_front();
                s_sel = 1'b1; s_isld = 1'b1; s_pop = 1'b1;
                s_rd = s_pkt[36:32]; s_data = s_pkt[31:0];
                if (ldValid && s_room) m_q.push_back({ldRd, ldData});
            end else if (ldValid) begin
                s_sel = 1'b1; s_isld = 1'b1; s_rd = ldRd; s_data = ldData;
            end
            if (s_empty || s_pop) m_age = 0;
            else if (aluValid && m_age < MAX_WAIT) m_age = m_age + 1;
            if (s_isld && s_rd != 0) m_busy[s_rd] = 1'b0;
            if (issueValid && issueIsLoad && issueRd != 0) m_busy[issueRd] = 1'b1;
            m_wen = s_sel && (s_rd != 0);
            if (s_sel) begin
                m_addr = s_rd;
                m_data = s_data;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_init) begin
            chk("m_wEn", 32'(wEn), 32'(m_wen));
            chk("m_addrD", 32'(addrD), 32'(m_addr));
            chk("m_dataD", dataD, m_data);
            chk("m_busy", busy, m_busy);
            chk("m_wbStall", 32'(wbStall), 32'(m_stall));
            chk("m_errWaw", 32'(errWaw), 32'(m_err));
            chk("m_ldReady", 32'(ldReady), 32'(m_q.size() < FIFO_DEPTH));
        end
    end

    task automatic idle();
        issueValid = 1'b0; issueIsLoad = 1'b0; issueRd = '0;
        aluValid = 1'b0; aluRd = '0; aluData = '0;
        ldValid = 1'b0; ldRd = '0; ldData = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic rdy_saved;

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        chk("rst_wEn", 32'(wEn), 0);
        chk("rst_addrD", 32'(addrD), 0);
        chk("rst_dataD", dataD, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wbStall", 32'(wbStall), 0);
        chk("rst_errWaw", 32'(errWaw), 0);
        chk("rst_ldReady", 32'(ldReady), 1);
        rst = 1'b0;

        // ALU only
        aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF;
        step();
        chk("alu_wEn", 32'(wEn), 1);
        chk("alu_addrD", 32'(addrD), 5);
        chk("alu_dataD", dataD, 32'hDEADBEEF);
        idle();
        step();
        chk("alu_wEn_off", 32'(wEn), 0);
        chk("alu_addr_hold", 32'(addrD), 5);

        // Load bypass with scoreboard
        issueValid = 1'b1; issueIsLoad = 1'b1; issueRd = 5'd7;
        step();
        chk("byp_busy7_set", 32'(busy[7]), 1);
        idle();
        ldValid = 1'b1; ldRd = 5'd7; ldData = 32'h12;
        step();
        chk("byp_wEn", 32'(wEn), 1);
        chk("byp_addrD", 32'(addrD), 7);
        chk("byp_dataD", dataD, 32'h12);
        chk("byp_busy7_clr", 32'(busy[7]), 0);
        idle();

        // Collision: ALU first, load one cycle later
        aluValid = 1'b1; aluRd = 5'd3; aluData = 32'hA;
        ldValid = 1'b1; ldRd = 5'd4; ldData = 32'hB;
        step();
        chk("col_addr1", 32'(addrD), 3);
        chk("col_data1", dataD, 32'hA);
        idle();
        step();
        chk("col_wEn2", 32'(wEn), 1);
        chk("col_addr2", 32'(addrD), 4);
        chk("col_data2", dataD, 32'hB);
        step();
        chk("col_wEn3", 32'(wEn), 0);

        // Back-pressure and starvation under continuous ALU traffic
        aluValid = 1'b1; aluRd = 5'd10;
        for (int i = 0; i < 6; i++) begin
            aluData = 32'(i);
            if (i < 3) begin
                ldValid = 1'b1; ldRd = 5'(11 + i); ldData = 32'hC0 + 32'(i);
            end
            step();
            if (i == 1) chk("bp_ldReady", 32'(ldReady), 0);
            if (i == 4) chk("bp_stall_pre", 32'(wbStall), 0);
        end
        chk("bp_stall", 32'(wbStall), 1);
        chk("bp_ldReady_full", 32'(ldReady), 0);
        aluValid = 1'b0;
        step();
        chk("drain_addr11", 32'(addrD), 11);
        chk("drain_data11", dataD, 32'hC0);
        chk("drain_stall_hold", 32'(wbStall), 1);
        step();
        chk("drain_addr12", 32'(addrD), 12);
        chk("drain_stall_fall", 32'(wbStall), 0);
        ldValid = 1'b0;
        step();
        chk("drain_addr13", 32'(addrD), 13);
        chk("drain_data13", dataD, 32'hC2);
        step();
        chk("drain_idle", 32'(wEn), 0);

        // Writes to x0 never enable the port
        aluValid = 1'b1; aluRd = 5'd0; aluData = 32'h1;
        ldValid = 1'b1; ldRd = 5'd0; ldData = 32'h2;
        step();
        chk("x0_alu_wEn", 32'(wEn), 0);
        idle();
        step();
        chk("x0_ld_wEn", 32'(wEn), 0);
        chk("x0_ld_data", dataD, 32'h2);

        // ALU write to a register with a pending load
        issueValid = 1'b1; issueIsLoad = 1'b1; issueRd = 5'd9;
        step();
        idle();
        aluValid = 1'b1; aluRd = 5'd9; aluData = 32'h5;
        step();
        chk("waw_err", 32'(errWaw), 1);
        chk("waw_wEn", 32'(wEn), 1);
        idle();
        step();
        chk("waw_sticky", 32'(errWaw), 1);

        // Reset with two buffered loads
        for (int i = 0; i < 2; i++) begin
            issueValid = 1'b1; issueIsLoad = 1'b1; issueRd = 5'(20 + i);
            aluValid = 1'b1; aluRd = 5'd1; aluData = 32'(i);
            ldValid = 1'b1; ldRd = 5'(20 + i); ldData = 32'(i + 100);
            step();
        end
        chk("rst2_full", 32'(ldReady), 0);
        idle();
        rst = 1'b1;
        step();
        chk("rst2_wEn", 32'(wEn), 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_ldReady", 32'(ldReady), 1);
        chk("rst2_errWaw", 32'(errWaw), 0);
        rst = 1'b0;
        step();
        chk("rst2_no_drain", 32'(wEn), 0);

        // Randomized traffic; the load source holds while not accepted
        rdy_saved = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!(ldValid && !rdy_saved)) begin
                ldValid = ($urandom_range(0, 2) == 0);
                ldRd    = 5'($urandom_range(0, 31));
                ldData  = $urandom;
            end
            aluValid    = ($urandom_range(0, 99) < (((c / 256) % 2) != 0 ? 85 : 40));
            aluRd       = 5'($urandom_range(0, 31));
            aluData     = $urandom;
            issueValid  = ($urandom_range(0, 1) == 1);
            issueIsLoad = ($urandom_range(0, 1) == 1);
            issueRd     = 5'($urandom_range(0, 31));
            rdy_saved   = ldReady && !rst;
            step();
        end
        idle();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
